// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizing, sample field slices and FSM states for the FFT frame streamer
package fft_pkg;
   localparam int N_POINTS = 32;
   localparam int SAMPLE_W = 64;
   localparam int IDX_W    = $clog2(N_POINTS);
   localparam int FRAME_W  = N_POINTS * SAMPLE_W;

   localparam int RE_HI = 63;
   localparam int RE_LO = 32;
   localparam int IM_HI = 31;
   localparam int IM_LO = 0;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;
endpackage

// File: rtl/fft_bitrev_idx.sv
// rtl/fft_bitrev_idx.sv - combinational bit-reversal of an FFT bin index
module fft_bitrev_idx #(
   parameter int IDX_W = 5
) (
   input  logic [IDX_W-1:0] idx,
   output logic [IDX_W-1:0] rev
);
   for (genvar b = 0; b < IDX_W; b++) begin : g_rev
      assign rev[b] = idx[IDX_W-1-b];
   end
endmodule

// File: rtl/fft_frame_streamer.sv
// rtl/fft_frame_streamer.sv - two-bank FFT result frame store streamed out one sample per cycle
module fft_frame_streamer #(
   parameter int N_POINTS = fft_pkg::N_POINTS,
   parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
   parameter bit BITREV   = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_POINTS*SAMPLE_W-1:0]  frame_in,
   input  logic                          frame_valid,
   output logic                          frame_ready,
   output logic [SAMPLE_W-1:0]           out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(N_POINTS)-1:0]   out_index,
   output logic                          out_last,
   output logic                          overflow
);
   import fft_pkg::*;

   localparam int IW = $clog2(N_POINTS);

   logic [N_POINTS*SAMPLE_W-1:0] bank [2];
   logic [1:0]    full, full_nxt;
   logic          wr_bank, rd_bank;
   state_t        state, state_nxt;
   logic [IW-1:0] cnt, cnt_nxt, cnt_rev, slot;
   logic          capture, fire, last_fire;

   // frame_ready comes straight from flags so out_ready never reaches it combinationally
   assign frame_ready = !full[wr_bank];
   assign capture     = frame_valid && frame_ready;
   assign out_valid   = (state == STREAM);
   assign out_index   = cnt;
   assign out_last    = out_valid && (cnt == IW'(N_POINTS-1));
   assign fire        = out_valid && out_ready;
   assign last_fire   = fire && out_last;

   fft_bitrev_idx #(.IDX_W(IW)) u_bitrev (
      .idx (cnt),
      .rev (cnt_rev)
   );

   assign slot     = BITREV ? cnt_rev : cnt;
   assign out_data = out_valid ? bank[rd_bank][slot*SAMPLE_W +: SAMPLE_W] : '0;

   always_ff @(posedge clk) begin
      if (capture) begin
         bank[wr_bank] <= frame_in;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      full_nxt  = full;
      // capture only targets an empty bank, the reader only frees a full one
      if (last_fire) full_nxt[rd_bank] = 1'b0;
      if (capture)   full_nxt[wr_bank] = 1'b1;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               state_nxt = STREAM;
               cnt_nxt   = '0;
            end
         end
         STREAM: begin
            if (fire) begin
               cnt_nxt = cnt + 1'b1;
               if (out_last && !full[~rd_bank]) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         full     <= 2'b00;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         full  <= full_nxt;
         if (capture)                     wr_bank  <= ~wr_bank;
         if (last_fire)                   rd_bank  <= ~rd_bank;
         if (frame_valid && !frame_ready) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb/tb_fft_frame_streamer.sv - self-checking bench for fft_frame_streamer (natural and bit-reversed instances)
module tb_fft_frame_streamer;
   import fft_pkg::*;

   localparam int NP = 32;
   localparam int SW = 64;
   localparam int FW = NP * SW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [FW-1:0] frame_in = '0;
   logic          frame_valid = 1'b0;
   logic          out_ready = 1'b0;

   logic          frame_ready0, frame_ready1, out_valid0, out_valid1;
   logic          out_last0, out_last1, overflow0, overflow1;
   logic [SW-1:0] out_data0, out_data1;
   logic [4:0]    out_index0, out_index1;

   fft_frame_streamer #(.N_POINTS(NP), .SAMPLE_W(SW), .BITREV(1'b0)) dut0 (
      .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
      .frame_ready(frame_ready0), .out_data(out_data0), .out_valid(out_valid0),
      .out_ready(out_ready), .out_index(out_index0), .out_last(out_last0), .overflow(overflow0)
   );

   fft_frame_streamer #(.N_POINTS(NP), .SAMPLE_W(SW), .BITREV(1'b1)) dut1 (
      .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
      .frame_ready(frame_ready1), .out_data(out_data1), .out_valid(out_valid1),
      .out_ready(out_ready), .out_index(out_index1), .out_last(out_last1), .overflow(overflow1)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int brev(input int k);
      int r = 0;
      for (int b = 0; b < 5; b++) if (k & (1 << b)) r |= 1 << (4 - b);
      return r;
   endfunction

   function automatic logic [FW-1:0] make_frame(input int tag);
      logic [FW-1:0] f;
      for (int i = 0; i < NP; i++) begin
         if (tag == 0) f[i*SW +: SW] = {32'(i), 32'(32 - i)};
         else          f[i*SW +: SW] = {32'(tag*1000 + i), 32'(tag ^ (i*7919))};
      end
      return f;
   endfunction

   // Model: FIFO of accepted frames; head streams from max(capture+1, previous finish)
   logic [FW-1:0] fq[$];
   int            capq[$];
   int            cyc = 0;
   int            beat = 0;
   int            last_finish = 0;
   bit            ovf_exp = 1'b0;
   bit            rec = 1'b0;
   logic [63:0]   obs0 [NP];
   logic [63:0]   obs1 [NP];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      bit            ev, acc;
      int            st, s;
      logic [FW-1:0] hf;
      if (!reset) begin
         fq.delete();
         capq.delete();
         beat = 0;
         last_finish = 0;
         ovf_exp = 1'b0;
         chk("rst_valid", {out_valid1, out_valid0}, 2'b00);
         chk("rst_data", out_data0 | out_data1, 64'd0);
         chk("rst_ready", {frame_ready1, frame_ready0}, 2'b11);
         chk("rst_ovf", {overflow1, overflow0}, 2'b00);
      end else begin
         ev = 1'b0;
         if (fq.size() > 0) begin
            st = (capq[0] + 1 > last_finish) ? capq[0] + 1 : last_finish;
            ev = (cyc >= st);
         end
         chk("frame_ready0", frame_ready0, fq.size() < 2);
         chk("frame_ready1", frame_ready1, fq.size() < 2);
         chk("overflow0", overflow0, ovf_exp);
         chk("overflow1", overflow1, ovf_exp);
         chk("out_valid0", out_valid0, ev);
         chk("out_valid1", out_valid1, ev);
         if (ev) begin
            hf = fq[0];
            s = brev(beat);
            chk("out_index0", out_index0, beat);
            chk("out_index1", out_index1, beat);
            chk("out_last0", out_last0, beat == NP - 1);
            chk("out_last1", out_last1, beat == NP - 1);
            chk("out_data0", out_data0, hf[beat*SW +: SW]);
            chk("out_data1", out_data1, hf[s*SW +: SW]);
         end else begin
            chk("gated_data0", out_data0, 64'd0);
            chk("gated_data1", out_data1, 64'd0);
         end
         acc = frame_valid && (fq.size() < 2);
         if (frame_valid && !acc) ovf_exp = 1'b1;
         if (ev && out_ready) begin
            if (rec) begin
               obs0[beat] = out_data0;
               obs1[beat] = out_data1;
            end
            beat++;
            if (beat == NP) begin
               beat = 0;
               void'(fq.pop_front());
               void'(capq.pop_front());
               last_finish = cyc + 1;
            end
         end
         if (acc) begin
            fq.push_back(frame_in);
            capq.push_back(cyc + 1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [FW-1:0] f);
      frame_in = f;
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nb;
      reset = 1'b0;
      step();
      step();
      chk("reset_index", out_index0, 5'd0);
      chk("reset_last", out_last0, 1'b0);
      reset = 1'b1;
      step();

      // single frame, natural and bit-reversed order, latency
      out_ready = 1'b1;
      rec = 1'b1;
      send(make_frame(0));
      chk("lat_idle", out_valid0, 1'b0);
      step();
      chk("lat_valid", out_valid0, 1'b1);
      repeat (40) step();
      rec = 1'b0;
      chk("nat_bin0", obs0[0], {32'd0, 32'd32});
      chk("nat_bin5", obs0[5], {32'd5, 32'd27});
      chk("nat_bin31", obs0[31], {32'd31, 32'd1});
      chk("rev_bin1", obs1[1], {32'd16, 32'd16});
      chk("rev_bin2", obs1[2], {32'd8, 32'd24});
      chk("rev_bin3", obs1[3], {32'd24, 32'd8});
      chk("rev_bin31", obs1[31], {32'd31, 32'd1});

      // random backpressure
      send(make_frame(3));
      for (int i = 0; i < 120; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      out_ready = 1'b1;
      repeat (40) step();
      chk("bp_drained", out_valid0, 1'b0);

      // double buffer, overflow, continuous drain
      out_ready = 1'b0;
      frame_in = make_frame(1);
      frame_valid = 1'b1;
      step();
      frame_in = make_frame(2);
      step();
      chk("full_after_b", frame_ready0, 1'b0);
      frame_in = make_frame(4);
      step();
      frame_valid = 1'b0;
      chk("ovf_set", overflow0, 1'b1);
      out_ready = 1'b1;
      nb = 0;
      for (int i = 0; i < 64; i++) begin
         nb += int'(out_valid0);
         step();
      end
      chk("no_bubble", 64'(nb), 64'd64);
      chk("ab_done", out_valid0, 1'b0);

      // free/capture race on the last handshake
      out_ready = 1'b0;
      send(make_frame(5));
      send(make_frame(10));
      out_ready = 1'b1;
      n = 0;
      while (!(out_valid0 && out_index0 == 5'd31) && n < 100) begin
         step();
         n++;
      end
      chk("race_found", 64'(n < 100), 64'd1);
      chk("race_refused", frame_ready0, 1'b0);
      send(make_frame(6));
      chk("race_ready_rise", frame_ready0, 1'b1);
      send(make_frame(7));
      repeat (80) step();

      // reset mid-stream
      send(make_frame(8));
      n = 0;
      while (!(out_valid0 && out_index0 == 5'd10) && n < 100) begin
         step();
         n++;
      end
      chk("mid_found", 64'(n < 100), 64'd1);
      reset = 1'b0;
      #1;
      chk("mid_valid", out_valid0, 1'b0);
      chk("mid_data", out_data0, 64'd0);
      chk("mid_index", out_index0, 5'd0);
      chk("mid_ready", frame_ready0, 1'b1);
      chk("mid_ovf", overflow0, 1'b0);
      step();
      step();
      reset = 1'b1;
      send(make_frame(9));
      step();
      chk("post_idx", out_index0, 5'd0);
      chk("post_data", out_data0, {32'd9000, 32'd9});
      repeat (40) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fft_frame_streamer.md
# fft_frame_streamer

Output-side companion to the 32-point butterfly FFT. It takes the FFT's parallel result frame, 32 complex samples of 64 bits each on a 2048-bit bus, and buffers it in a two-bank frame store. It then streams the samples out one per cycle over a valid/ready interface, optionally reordering from bit-reversed to natural bin order. It sits between the `butterfly` output bus and any serial consumer: DMA, result FIFO or file dump.

## Interface
- `N_POINTS`, 32: samples per frame; power of two.
- `SAMPLE_W`, 64: bits per complex sample; `[63:32]` real, `[31:0]` imag, two's complement.
- `BITREV`, 1: 1 means output bin k is read from frame slot bitrev(k); 0 means natural slot order.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `frame_in` in N_POINTS*SAMPLE_W: result frame; slot i is `[i*SAMPLE_W +: SAMPLE_W]`.
- `frame_valid` in 1: frame_in holds a complete frame this cycle.
- `frame_ready` out 1: a bank is free. Equals !full[wr_bank], driven from registers only.
- `out_data` out SAMPLE_W: streamed sample.
- `out_valid` out 1: out_data, out_index and out_last are valid.
- `out_ready` in 1: consumer accepts.
- `out_index` out log2(N_POINTS): output bin number k.
- `out_last` out 1: high with bin N_POINTS-1.
- `overflow` out 1: sticky. Set when a frame arrives with no free bank.

## Operation
- Storage: two frame banks with flags full[1:0], a write pointer wr_bank and a read pointer rd_bank.
- Capture: when frame_valid && frame_ready, bank[wr_bank] <= frame_in, full[wr_bank] <= 1 and wr_bank toggles.
- Drop: when frame_valid && !frame_ready, the frame is discarded and overflow <= 1. Only reset clears overflow.
- FSM states are IDLE and STREAM, with counter cnt of width log2(N_POINTS).
  - IDLE: if full[rd_bank], go to STREAM with cnt = 0.
  - STREAM: out_valid = 1 and out_index = cnt.
  - out_data = bank[rd_bank][slot], where slot = BITREV ? bitrev(cnt) : cnt.
  - out_last = (cnt == N_POINTS-1).
  - On each out_valid && out_ready, cnt increments.
- End of frame: on the handshake with out_last, full[rd_bank] <= 0, rd_bank toggles and cnt wraps to 0.
  - If the other bank is full, the FSM stays in STREAM with no bubble cycle.
  - Otherwise it returns to IDLE.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable. out_valid never deasserts before its handshake.
- Gating: out_data = 0 whenever out_valid = 0.
- Simultaneous free and capture: a bank freed on edge t is offered via frame_ready only after edge t. There is no combinational path from out_ready to frame_ready.
- Simultaneous capture and stream: capture into the bank not being read proceeds on the same edge.
- Reset at any time, including mid-frame: all state clears immediately, and the in-flight frame and any buffered frame are lost. Bank contents are not reset.

## Timing
- Reset values:
  - out_valid = 0, out_last = 0, out_index = 0, out_data = 0, overflow = 0.
  - full = 00, wr_bank = rd_bank = 0, state IDLE.
  - frame_ready = 1.
- Latency: a frame captured on edge t gives out_valid = 1 after edge t+1.
- Throughput: with out_ready held at 1, one frame takes N_POINTS cycles. Back-to-back buffered frames stream continuously.
- Capacity: up to two frames may be buffered. A third arriving while both banks are full is dropped.

## Structure
- Package `fft_pkg`:
  - N_POINTS, SAMPLE_W and IDX_W = $clog2(N_POINTS).
  - Real/imag slice localparams.
  - FSM state enum {IDLE, STREAM}.
- Sub-module `fft_bitrev_idx`: a parameterised IDX_W combinational index reverser. The same block is reusable by the input-side loader.

## Test plan
- **Single frame, natural order:** BITREV=0. Slot i = {real=i, imag=32-i}, one frame_valid pulse, out_ready=1. out_valid rises one cycle after capture. It outputs bins 0..31 with out_data {i, 32-i} over 32 consecutive cycles. out_last is high only at index 31.
- **Bit-reverse order:** BITREV=1, same frame. Index 1 carries slot 16, index 2 slot 8, index 3 slot 24, index 31 slot 31.
- **Backpressure:** toggle out_ready pseudo-randomly at 50%. Every held beat stays stable. All 32 beats appear in order with no duplicates or gaps.
- **Double buffer and overflow:** hold out_ready=0 and pulse frame_valid for frames A, B and C on consecutive cycles. A and B are accepted, frame_ready drops after B, C is dropped and overflow=1. Then release out_ready: A then B stream as 64 continuous beats with no bubble.
- **Free/capture race:** send frame B on the cycle of A's out_last handshake while the other bank is full. B is refused, frame_ready rises one cycle later and a retry is accepted.
- **Reset mid-stream:** assert reset at beat 10 of a frame. All outputs are 0 immediately and frame_ready=1. After release, a new frame streams from index 0 and the old data never appears.
